// File: rtl/alu_pkg.sv
// Shared ALU definitions: the operation encoding and the ALU result width.
package alu_pkg;

  typedef enum logic [1:0] {
    nop = 2'd0,
    add = 2'd1,
    sub = 2'd2
  } operation_t;

  localparam int ALU_WIDTH = 6;

endpackage

// File: rtl/alu_result_fifo.sv
// Show-ahead result FIFO behind the ALU, with a sticky overflow flag for dropped words.
// Optional saturating drop counter enabled by the macro ALU_RESULT_FIFO_DROPCNT_EN.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       overflow
`ifdef ALU_RESULT_FIFO_DROPCNT_EN
  ,
  input  logic                       drop_clr,
  output logic [7:0]                 drop_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  // Handshake: the producer has no ready; a word offered with in_valid is either
  // stored or dropped at the edge. The consumer pops when out_valid && out_ready.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             push, pop, drop;

  assign out_valid = (level_q != '0);
  assign full      = (level_q == LW'(DEPTH));
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign pop  = out_valid & out_ready;
  assign push = in_valid & (~full | pop);
  assign drop = in_valid & full & ~pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q | drop;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; pointers and level alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= in_data;
  end

`ifdef ALU_RESULT_FIFO_DROPCNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_clr)                        drop_cnt_d = '0;
    else if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo (WIDTH=6, DEPTH=4): vector table, corner
// sequences and a random burst, all scored against a queue model.
module tb_alu_result_fifo;

  localparam int W = 6;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   level;
  logic         full;
  logic         overflow;
`ifdef ALU_RESULT_FIFO_DROPCNT_EN
  logic         drop_clr;
  logic [7:0]   drop_cnt;
`endif

  alu_result_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .full      (full),
    .overflow  (overflow)
`ifdef ALU_RESULT_FIFO_DROPCNT_EN
    ,
    .drop_clr  (drop_clr),
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard state: expected FIFO contents and sticky flags.
  logic [W-1:0] exp_q[$];
  logic         ovf_m;
  int           dcnt_m;
  int           n_vec;
  int           n_err;

  typedef struct {
    logic         rst_first;
    logic         iv;
    logic [W-1:0] d;
    logic         rdy;
    int           lvl;
    logic         ovf;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    ovf_m  = 1'b0;
    dcnt_m = 0;
  endtask

  // One clock cycle: drive, score the head before the edge, update the model, check after.
  task automatic step(input logic iv, input logic [W-1:0] d, input logic rdy);
    logic pop_m;
    logic clr_m;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = rdy;
    #1;
    check("out_valid_pre", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("head_data", out_data, exp_q[0]);
    else                   check("empty_data", out_data, 0);
    pop_m = (exp_q.size() != 0) && rdy;
`ifdef ALU_RESULT_FIFO_DROPCNT_EN
    clr_m = drop_clr;
`else
    clr_m = 1'b0;
`endif
    if (pop_m) void'(exp_q.pop_front());
    if (iv && (exp_q.size() < D)) exp_q.push_back(d);
    else if (iv) begin
      ovf_m = 1'b1;
      if (!clr_m && dcnt_m < 255) dcnt_m++;
    end
    if (clr_m) dcnt_m = 0;
    @(posedge clk);
    #1;
    check("level", level, exp_q.size());
    check("full", full, exp_q.size() == D);
    check("overflow", overflow, ovf_m);
`ifdef ALU_RESULT_FIFO_DROPCNT_EN
    check("drop_cnt", drop_cnt, dcnt_m);
`endif
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    ovf_m = 1'b0;
    dcnt_m = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
`ifdef ALU_RESULT_FIFO_DROPCNT_EN
    drop_clr = 1'b0;
`endif

    // Scenario 1
    vecs[0]  = '{1'b0, 1'b1, 6'h05, 1'b0, 1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 6'h00, 1'b1, 0, 1'b0};
    // Scenario 2: fill, drop 0x3F, drain 01..04
    vecs[2]  = '{1'b0, 1'b1, 6'h01, 1'b0, 1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 6'h02, 1'b0, 2, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 6'h03, 1'b0, 3, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 6'h04, 1'b0, 4, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 6'h3F, 1'b0, 4, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 6'h00, 1'b1, 3, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 6'h00, 1'b1, 2, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 6'h00, 1'b1, 1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 6'h00, 1'b1, 0, 1'b1};
    // Scenario 3: fill, push+pop while full, drain 02,03,04,2A
    vecs[11] = '{1'b1, 1'b1, 6'h01, 1'b0, 1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 6'h02, 1'b0, 2, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 6'h03, 1'b0, 3, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 6'h04, 1'b0, 4, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 6'h2A, 1'b1, 4, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 6'h00, 1'b1, 3, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 6'h00, 1'b1, 2, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 6'h00, 1'b1, 1, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 6'h00, 1'b1, 0, 1'b0};

    #3;
    check("rst_level", level, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_out_data", out_data, 0);
`ifdef ALU_RESULT_FIFO_DROPCNT_EN
    check("rst_drop_cnt", drop_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      if (vecs[i].rst_first) do_reset();
      step(vecs[i].iv, vecs[i].d, vecs[i].rdy);
      check($sformatf("vec%0d_level", i), level, vecs[i].lvl);
      check($sformatf("vec%0d_overflow", i), overflow, vecs[i].ovf);
    end
    check("s1_s3_drained_data", out_data, 0);

    // Scenario 4: streaming through a nearly empty FIFO wraps the pointers
    for (int i = 0; i < 10; i++) begin
      step(1'b1, W'(i), 1'b1);
      check("s4_level_le1", level <= 3'd1, 1);
    end
    step(1'b0, '0, 1'b1);
    check("s4_level_end", level, 0);
    check("s4_overflow", overflow, 0);

    // Scenario 5: overflow set, level 3, then reset mid-cycle
    for (int i = 0; i < 5; i++) step(1'b1, W'(6'h20 + i), 1'b0);
    step(1'b0, '0, 1'b1);
    check("s5_level3", level, 3);
    check("s5_ovf_set", overflow, 1);
    #2;
    rst = 1'b1;
    #1;
    check("s5_async_out_valid", out_valid, 0);
    check("s5_async_level", level, 0);
    check("s5_async_overflow", overflow, 0);
    check("s5_async_out_data", out_data, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    ovf_m  = 1'b0;
    dcnt_m = 0;
    step(1'b1, 6'h11, 1'b0);
    check("s5_first_push", out_data, 6'h11);

    // Random traffic, scored by the queue model
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, W'($urandom_range(0, 63)), $urandom_range(0, 1) == 1);
    for (int i = 0; i < D + 1; i++) step(1'b0, '0, 1'b1);
    check("rand_drained", level, 0);

`ifdef ALU_RESULT_FIFO_DROPCNT_EN
    // Scenario 6: counter saturation and clear priority
    do_reset();
    for (int i = 0; i < D; i++) step(1'b1, W'(i), 1'b0);
    for (int i = 0; i < 260; i++) step(1'b1, 6'h3F, 1'b0);
    check("s6_drop_cnt_sat", drop_cnt, 255);
    drop_clr = 1'b1;
    step(1'b1, 6'h3F, 1'b0);
    drop_clr = 1'b0;
    check("s6_drop_cnt_clr", drop_cnt, 0);
    step(1'b1, 6'h3F, 1'b0);
    check("s6_drop_cnt_after", drop_cnt, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_result_fifo.md
ALU_RESULT_FIFO -- requirements
Module: alu_result_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 6, giving the result data width; it matches the upstream ALU output width.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of entries; it must be a power of two and at least 2.
REQ-003 Port clk, input, 1 bit: clock, rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port in_data, input, WIDTH bits: ALU result word.
REQ-006 Port in_valid, input, 1 bit: in_data is valid this cycle; there is no backpressure to the producer.
REQ-007 Port out_data, output, WIDTH bits: head entry.
REQ-008 Port out_valid, output, 1 bit: the FIFO is non-empty.
REQ-009 Port out_ready, input, 1 bit: the consumer accepts the head entry.
REQ-010 Port level, output, $clog2(DEPTH+1) bits: current occupancy.
REQ-011 Port full, output, 1 bit: level equals DEPTH.
REQ-012 Port overflow, output, 1 bit: sticky flag, set when a result was dropped.

Function
REQ-013 A push SHALL occur on a rising clk edge when in_valid=1 and the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-014 A pop SHALL occur on a rising clk edge when out_valid=1 and out_ready=1.
REQ-015 out_data SHALL present the head entry with no read latency (show-ahead).
REQ-016 out_data SHALL be 0 when the FIFO is empty.
REQ-017 A word pushed at edge N SHALL be visible on out_valid/out_data in the cycle after edge N when the FIFO was empty before that edge; there is no empty-cycle bypass.
REQ-018 Read and write pointers SHALL be log2(DEPTH) bits wide and SHALL wrap from DEPTH-1 to 0.
REQ-019 level SHALL be +1 on a push alone, -1 on a pop alone, and unchanged on a simultaneous push and pop.
REQ-020 When full, in_valid=1 and no pop occur in the same cycle, in_data SHALL be discarded, storage SHALL be unchanged, and overflow SHALL be set at that edge.
REQ-021 When full, in_valid=1 and a pop occur in the same cycle, both operations SHALL proceed, level SHALL stay at DEPTH, and overflow SHALL NOT be set.
REQ-022 When empty, out_ready SHALL be ignored and a push SHALL still occur.
REQ-023 Entries SHALL be delivered in arrival order, with none duplicated and none lost except per REQ-020.
REQ-024 overflow SHALL be cleared only by rst.
REQ-025 full and out_valid SHALL be derived combinationally from level.

Reset
REQ-026 When rst=1, the following SHALL take effect immediately, independent of clk: pointers=0, level=0, overflow=0, out_valid=0, full=0, out_data=0.
REQ-027 Reset SHALL discard all stored entries.
REQ-028 The storage array need not be cleared by reset.
REQ-029 A push or pop request in a cycle where rst=1 SHALL have no effect.
REQ-030 After deassertion of rst, the first push SHALL be accepted at the first rising edge with in_valid=1.

Configuration
REQ-031 Macro ALU_RESULT_FIFO_DROPCNT_EN, when defined, SHALL add input drop_clr (1 bit) and output drop_cnt (8 bits).
REQ-032 With that macro defined, drop_cnt SHALL increment by 1 on every drop per REQ-020 and SHALL saturate at 255.
REQ-033 With that macro defined, drop_clr=1 SHALL zero drop_cnt at the next edge, taking priority over a simultaneous increment; rst SHALL also zero drop_cnt.
REQ-034 Without the macro, neither port SHALL exist and no counter logic SHALL be present; all other behaviour SHALL be identical.

Structure
REQ-035 Shared package alu_pkg SHALL hold operation_t (nop=0, add=1, sub=2) and the constant ALU_WIDTH=6.
REQ-036 This block SHALL NOT depend on operation_t.
REQ-037 The block SHALL be a single module with storage, pointers and occupancy inline; no sub-module is needed.

Verification (WIDTH=6, DEPTH=4)
REQ-038 Scenario 1: push 0x05 with out_ready=0 -> next cycle out_valid=1, out_data=0x05, level=1; out_ready=1 for one cycle -> level=0, out_valid=0, out_data=0.
REQ-039 Scenario 2: push 0x01, 0x02, 0x03, 0x04 with out_ready=0 -> full=1, level=4; push 0x3F -> overflow=1, level=4, and drain yields 0x01..0x04 in order.
REQ-040 Scenario 3: fill to 4, then one cycle with in_valid=1 (0x2A) and out_ready=1 -> level=4, overflow=0, and drain yields 0x02, 0x03, 0x04, 0x2A.
REQ-041 Scenario 4: 10 consecutive pushes 0..9 with out_ready=1 throughout -> outputs 0..9 in order, level never above 1, overflow=0, confirming pointer wrap.
REQ-042 Scenario 5: level=3, assert rst mid-clock-cycle -> out_valid=0, level=0 and overflow=0 before the next edge; after release, push 0x11 -> out_data=0x11.
REQ-043 Scenario 6 (ALU_RESULT_FIFO_DROPCNT_EN defined): 260 drops while full -> drop_cnt=255; drop_clr=1 together with a drop -> drop_cnt=0.
